fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end on the consumer side of the program counter.
- Takes the current PC each cycle, issues a ROM read, and captures the returned instruction word together with its PC in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Back-pressures the PC through `stall` and discards wrong-path fetches on `flush`, which is driven by the same branch signal that redirects the PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pc_in  in  RomAddress  current PC from the program counter.
- stall  out  1  hold the PC; drives the PC's stall input.
- flush  in  1  branch taken this cycle; same signal as the PC's should_branch.
- rom_en  out  1  ROM read request.
- rom_addr  out  RomAddress  ROM read address; equals pc_in.
- rom_data  in  UWord  ROM read data, valid exactly one cycle after rom_en.
- out_valid  out  1  an instruction is available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  UWord  head instruction word.
- out_pc  out  RomAddress  PC of the head instruction.

Behaviour:
- State:
  - FIFO storage of DEPTH entries, each holding {UWord instr, RomAddress pc}.
  - rd_ptr and wr_ptr, each PTR_W bits, wrapping modulo DEPTH.
  - count, PTR_W+1 bits.
  - inflight_v (1 bit) and inflight_pc (RomAddress).
- Reset (asynchronous, reset==0): count=0, pointers=0, inflight_v=0. While reset is low: out_valid=0, stall=0, rom_en=0. Storage contents are don't-care.
- Issue (combinational):
  - rom_en = reset && !flush && !stall.
  - rom_addr = pc_in.
  - stall = (count + inflight_v) >= DEPTH. Credit is conservative: a pop in the current cycle does not free a slot until the next cycle.
- Capture:
  - At each posedge, inflight_v <= rom_en and inflight_pc <= pc_in.
  - If inflight_v && !flush, {rom_data, inflight_pc} is written at wr_ptr and wr_ptr increments.
- Pop: when out_valid && out_ready && !flush, rd_ptr increments.
- Head outputs: out_valid = (count != 0); out_instr and out_pc show the rd_ptr entry.
- Count rules:
  - Push and pop in the same cycle: count is unchanged.
  - Push can never occur while the FIFO is full, because the stall credit guarantees a slot.
  - Pop while empty is impossible, since out_valid=0.
- Flush has priority over push, pop and issue. In the flush cycle:
  - count <= 0 and rd_ptr <= wr_ptr.
  - inflight_v <= 0, so rom_data returning in the next cycle is dropped.
  - No ROM request is issued.
  - The PC loads the branch target at the same edge; the target is fetched in the following cycle.
- Stall interaction: while stall is high the PC holds, so the same pc_in is presented again and issued once credit frees. No address is skipped or duplicated.
- Latency:
  - A PC issued in cycle N is captured at the end of cycle N+1 and appears on out_valid in cycle N+2.
  - Sustained throughput is 1 instruction/cycle when out_ready is held at 1.
- Reset asserted mid-operation: all state clears immediately and any outstanding ROM response is ignored.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- When defined:
  - Adds 32-bit outputs perf_fetched, perf_flushed and perf_stall_cycles.
  - perf_fetched counts captured pushes.
  - perf_flushed counts valid entries discarded by flush: count plus inflight_v at the flush edge.
  - perf_stall_cycles counts cycles with stall=1.
  - All three counters clear on reset and saturate at the maximum value.
- When undefined: the ports and logic are absent, and the block's behaviour is otherwise identical.

Decomposition:
- Shared types: RomAddress and UWord from the shared types header.
- Add FetchEntry, a struct {UWord instr; RomAddress pc}, to the shared instruction types header so decode can consume it directly.
- One natural sub-module: fetch_fifo_mem, the DEPTH-entry register array with a single write port, a single read port and flush-as-pointer-reset.

Test Plan:
- Reset release, out_ready=1, ROM returns data = address ^ 0xA5A5A5A5:
  - out_pc sequence is 0, 4, 8, ...
  - First out_valid appears 2 cycles after the first rom_en.
  - One instruction per cycle thereafter.
- out_ready=0 from the start:
  - stall rises once count + inflight_v reaches 4.
  - pc_in is held at 0x10; no rom_en while stalled.
  - After raising out_ready, out_pc continues 0x10, 0x14 with no gap or duplicate.
- flush pulse with 3 entries queued and 1 in flight, PC redirected to 0x8:
  - Next cycle: out_valid=0 and the old rom_data is dropped.
  - The next delivered out_pc is 0x8.
- Simultaneous push and pop with count=2: count stays 2 and the FIFO order is preserved.
- Pointer wrap: stream 3×DEPTH instructions with out_ready toggling every cycle. The output order matches the issue order exactly.
- reset driven low mid-stream with 2 entries queued:
  - out_valid and stall drop immediately, without waiting for a clock edge.
  - After release, the first delivered out_pc is 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch types: ROM address and word, the fetch-queue entry consumed by decode,
// and the saturating-add helper used by the optional performance counters.
package fetch_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int PERF_W = 32;

  typedef logic [ADDR_W-1:0] RomAddress;
  typedef logic [WORD_W-1:0] UWord;
  typedef logic [PERF_W-1:0] perf_cnt_t;

  typedef struct packed {
    UWord      instr;
    RomAddress pc;
  } FetchEntry;

  function automatic perf_cnt_t sat_add(input perf_cnt_t a, input perf_cnt_t b);
    logic [PERF_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PERF_W] ? '1 : sum[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// DEPTH-entry fetch FIFO storage: one write port, one read port, and a flush that
// discards everything by snapping the read pointer onto the write pointer.
module fetch_fifo_mem
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  FetchEntry push_data,
  input  logic      pop,
  input  logic      flush,
  output FetchEntry head
);

  FetchEntry        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: the array has no reset; occupancy lives in the pointers and count, so stale
  // entries are never observed and the storage stays plain flops with no reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues ROM reads from the PC, queues {instr, pc} pairs and
// hands them to decode over valid/ready. Optional counters: define FETCH_QUEUE_PERF_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  RomAddress pc_in,
  output logic      stall,
  input  logic      flush,
  output logic      rom_en,
  output RomAddress rom_addr,
  input  UWord      rom_data,
  output logic      out_valid,
  input  logic      out_ready,
  output UWord      out_instr,
  output RomAddress out_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output perf_cnt_t perf_fetched,
  output perf_cnt_t perf_flushed,
  output perf_cnt_t perf_stall_cycles
`endif
);

  localparam logic [PTR_W+1:0] FULL_CREDIT = (PTR_W+2)'(DEPTH);

  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic [PTR_W+1:0] credit_used;
  logic             inflight_v;
  RomAddress        inflight_pc;
  logic             push;
  logic             pop;
  FetchEntry        head;

  // A request in flight already owns a slot, so a pop only frees credit next cycle.
  assign credit_used = (PTR_W+2)'(count) + (PTR_W+2)'(inflight_v);
  assign stall       = credit_used >= FULL_CREDIT;
  assign rom_en      = reset && !flush && !stall;
  assign rom_addr    = pc_in;

  assign out_valid = (count != '0);
  assign push      = inflight_v && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  always_comb begin
    // NOTE: default first so every path assigns count_next; a missing branch would infer a latch.
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      count       <= count_next;
      inflight_v  <= rom_en;
      inflight_pc <= pc_in;
    end
  end

  fetch_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{instr: rom_data, pc: inflight_pc}),
    .pop       (pop),
    .flush     (flush),
    .head      (head)
  );

`ifdef FETCH_QUEUE_PERF_EN
  // Flushed count covers queued entries plus the response that is about to be dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched      <= '0;
      perf_flushed      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (push)  perf_fetched      <= sat_add(perf_fetched, perf_cnt_t'(1));
      if (flush) perf_flushed      <= sat_add(perf_flushed, perf_cnt_t'(credit_used));
      if (stall) perf_stall_cycles <= sat_add(perf_stall_cycles, perf_cnt_t'(1));
    end
  end
`endif

endmodule
